// File: rtl/hpdcache_mem_read_responder_pkg.sv
// rtl/hpdcache_mem_read_responder_pkg.sv - shared types for the memory read responder
package hpdcache_mem_read_responder_pkg;

  // Storage widths of the queued request; the top zero-extends its narrower fields into these
  localparam int unsigned MEM_REQ_ADDR_MAX_W = 64;
  localparam int unsigned MEM_REQ_ID_MAX_W   = 8;

  typedef logic [7:0] hpdcache_mem_len_t;
  typedef logic [2:0] hpdcache_mem_size_t;

  typedef struct packed {
    logic [MEM_REQ_ADDR_MAX_W-1:0] addr;
    hpdcache_mem_len_t             len;
    hpdcache_mem_size_t            size;
    logic [MEM_REQ_ID_MAX_W-1:0]   id;
  } mem_read_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } responder_state_e;

  // log2 of the beat size in bytes for a given data bus width
  function automatic hpdcache_mem_size_t beat_size_log2(input int unsigned data_width);
    return hpdcache_mem_size_t'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/hpdcache_mem_read_responder_if.sv
// rtl/hpdcache_mem_read_responder_if.sv - memory read request/response channel bundle
interface hpdcache_mem_read_responder_if #(
  parameter int unsigned PA_WIDTH       = 49,
  parameter int unsigned MEM_DATA_WIDTH = 512,
  parameter int unsigned MEM_ID_WIDTH   = 4
) ();
  import hpdcache_mem_read_responder_pkg::*;

  logic                      mem_req_valid_i;
  logic                      mem_req_ready_o;
  logic [PA_WIDTH-1:0]       mem_req_addr_i;
  hpdcache_mem_len_t         mem_req_len_i;
  hpdcache_mem_size_t        mem_req_size_i;
  logic [MEM_ID_WIDTH-1:0]   mem_req_id_i;

  logic                      mem_resp_valid_o;
  logic                      mem_resp_ready_i;
  logic [MEM_DATA_WIDTH-1:0] mem_resp_data_o;
  logic [MEM_ID_WIDTH-1:0]   mem_resp_id_o;
  logic                      mem_resp_last_o;
  logic                      mem_resp_error_o;

  // Requester side (the miss handler)
  modport master (
    output mem_req_valid_i, mem_req_addr_i, mem_req_len_i, mem_req_size_i, mem_req_id_i,
    output mem_resp_ready_i,
    input  mem_req_ready_o,
    input  mem_resp_valid_o, mem_resp_data_o, mem_resp_id_o, mem_resp_last_o, mem_resp_error_o
  );

  // Memory side (this responder)
  modport slave (
    input  mem_req_valid_i, mem_req_addr_i, mem_req_len_i, mem_req_size_i, mem_req_id_i,
    input  mem_resp_ready_i,
    output mem_req_ready_o,
    output mem_resp_valid_o, mem_resp_data_o, mem_resp_id_o, mem_resp_last_o, mem_resp_error_o
  );

endinterface

// File: rtl/hpdcache_mem_req_fifo.sv
// rtl/hpdcache_mem_req_fifo.sv - synchronous FIFO of pending read requests
module hpdcache_mem_req_fifo
  import hpdcache_mem_read_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_push,
  input  mem_read_req_t i_push_data,
  output logic          o_full,
  input  logic          i_pop,
  output mem_read_req_t o_head,
  output logic          o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  mem_read_req_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Overflowing pushes and underflowing pops are ignored rather than corrupting state
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Entry storage, written at the tail; contents need no reset since the count gates reads
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of 2 so the pointers wrap on their own
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hpdcache_mem_read_responder.sv
// rtl/hpdcache_mem_read_responder.sv - fixed-latency memory read responder with address-pattern data
module hpdcache_mem_read_responder
  import hpdcache_mem_read_responder_pkg::*;
#(
  parameter int unsigned         PA_WIDTH       = 49,
  parameter int unsigned         MEM_DATA_WIDTH = 512,
  parameter int unsigned         MEM_ID_WIDTH   = 4,
  parameter int unsigned         REQ_FIFO_DEPTH = 4,
  parameter int unsigned         LATENCY        = 3,
  parameter logic [PA_WIDTH-1:0] ERR_BASE       = '1,
  parameter logic [63:0]         PATTERN_SEED   = 64'h0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  hpdcache_mem_read_responder_if.slave  mem
);

  localparam int unsigned        BEAT_BYTES = MEM_DATA_WIDTH / 8;
  localparam int unsigned        OFFSET_W   = $clog2(BEAT_BYTES);
  localparam int unsigned        WORDS      = MEM_DATA_WIDTH / 64;
  localparam hpdcache_mem_size_t BEAT_SIZE  = beat_size_log2(MEM_DATA_WIDTH);

  responder_state_e          r_state;
  logic [7:0]                r_cnt;
  logic [7:0]                r_beat;
  hpdcache_mem_len_t         r_len;
  logic [MEM_ID_WIDTH-1:0]   r_id;
  logic [PA_WIDTH-1:0]       r_beat_addr;
  logic                      r_err;
  logic                      r_valid;
  logic                      r_last;

  mem_read_req_t             w_req_entry;
  mem_read_req_t             w_head;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push_req;
  logic                      w_beat_done;
  logic                      w_pop;
  logic [PA_WIDTH-1:0]       w_head_aligned;
  logic                      w_head_err;
  logic [MEM_DATA_WIDTH-1:0] w_data;
  logic                      w_unused_head;

  // Ready depends only on FIFO occupancy, never on the response side
  assign mem.mem_req_ready_o = !w_full;
  assign w_push_req          = mem.mem_req_valid_i && !w_full;

  // Pack the incoming request into the queue entry format
  always_comb begin
    w_req_entry      = '0;
    w_req_entry.addr = MEM_REQ_ADDR_MAX_W'(mem.mem_req_addr_i);
    w_req_entry.len  = mem.mem_req_len_i;
    w_req_entry.size = mem.mem_req_size_i;
    w_req_entry.id   = MEM_REQ_ID_MAX_W'(mem.mem_req_id_i);
  end

  hpdcache_mem_req_fifo #(
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (mem.mem_req_valid_i),
    .i_push_data (w_req_entry),
    .o_full      (w_full),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty)
  );

  // Size, offset bits and upper storage bits of the head entry are not needed downstream
  assign w_unused_head = ^w_head;

  assign w_head_aligned = {w_head.addr[PA_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign w_head_err     = (w_head_aligned >= ERR_BASE);

  // The head is taken when idle, or straight from the final beat of the current burst
  assign w_beat_done = r_valid && mem.mem_resp_ready_i;
  assign w_pop       = !w_empty &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_BURST) && w_beat_done && r_last));

  // Sequencing FSM: latency countdown, beat stepping and next-request hand-off
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_len       <= '0;
      r_id        <= '0;
      r_beat_addr <= '0;
      r_err       <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_BURST;
            r_valid <= 1'b1;
            r_last  <= (r_len == 8'd0);
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_BURST: begin
          if (w_beat_done) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= w_empty ? ST_IDLE : ST_WAIT;
            end else begin
              r_beat      <= r_beat + 8'd1;
              r_beat_addr <= r_beat_addr + PA_WIDTH'(BEAT_BYTES);
              r_last      <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Loading the popped head; valid is still low here, so nothing visible moves mid-beat
      if (w_pop) begin
        r_cnt       <= 8'(LATENCY - 1);
        r_beat      <= '0;
        r_len       <= w_head.len;
        r_id        <= w_head.id[MEM_ID_WIDTH-1:0];
        r_beat_addr <= w_head_aligned;
        r_err       <= w_head_err;
      end
    end
  end

  // Beat data: each 64-bit word is its own byte address, seeded; forced to zero on error or idle
  always_comb begin
    logic [63:0] w_word;
    w_data = '0;
    w_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      w_word                = '0;
      w_word[PA_WIDTH-1:0]  = r_beat_addr + PA_WIDTH'(8 * w);
      if (r_valid && !r_err) begin
        w_data[w*64 +: 64] = w_word ^ PATTERN_SEED;
      end
    end
  end

  assign mem.mem_resp_valid_o = r_valid;
  assign mem.mem_resp_data_o  = w_data;
  assign mem.mem_resp_id_o    = r_id;
  assign mem.mem_resp_last_o  = r_last;
  assign mem.mem_resp_error_o = r_valid && r_err;

`ifndef HPDCACHE_ASSERT_OFF
  // Requesters must ask for full-width beats; anything else is a wiring error upstream
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push_req) begin
      assert (mem.mem_req_size_i == BEAT_SIZE)
        else $error("mem_req_size_i does not match the data bus width");
    end
  end
`endif

endmodule

// File: tb/tb_hpdcache_mem_read_responder.sv
// tb/tb_hpdcache_mem_read_responder.sv - directed self-checking bench for the memory read responder
module tb_hpdcache_mem_read_responder;

  localparam int unsigned PA_W   = 49;
  localparam int unsigned DW     = 512;
  localparam int unsigned IDW    = 4;
  localparam logic [63:0] E_SEED = 64'hA5A5_0000_0000_5A5A;

  logic clk = 1'b0;
  logic rst;
  logic rsp_ready;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hpdcache_mem_read_responder_if #(.PA_WIDTH(PA_W), .MEM_DATA_WIDTH(DW), .MEM_ID_WIDTH(IDW)) m_if ();
  hpdcache_mem_read_responder_if #(.PA_WIDTH(PA_W), .MEM_DATA_WIDTH(DW), .MEM_ID_WIDTH(IDW)) e_if ();

  assign m_if.mem_resp_ready_i = rsp_ready;
  assign e_if.mem_resp_ready_i = rsp_ready;

  hpdcache_mem_read_responder #(
    .PA_WIDTH(PA_W), .MEM_DATA_WIDTH(DW), .MEM_ID_WIDTH(IDW),
    .REQ_FIFO_DEPTH(4), .LATENCY(3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mem   (m_if)
  );

  hpdcache_mem_read_responder #(
    .PA_WIDTH(PA_W), .MEM_DATA_WIDTH(DW), .MEM_ID_WIDTH(IDW),
    .REQ_FIFO_DEPTH(4), .LATENCY(3),
    .ERR_BASE(49'h0_0000_8000_0000), .PATTERN_SEED(E_SEED)
  ) dut_err (
    .clk_i (clk),
    .rst_i (rst),
    .mem   (e_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic get(input int inst, output logic v, output logic [63:0] w0, output logic [63:0] w7,
                     output logic [3:0] id, output logic last, output logic err, output logic rdy);
    if (inst == 0) begin
      v = m_if.mem_resp_valid_o; w0 = m_if.mem_resp_data_o[63:0]; w7 = m_if.mem_resp_data_o[511:448];
      id = m_if.mem_resp_id_o; last = m_if.mem_resp_last_o; err = m_if.mem_resp_error_o;
      rdy = m_if.mem_req_ready_o;
    end else begin
      v = e_if.mem_resp_valid_o; w0 = e_if.mem_resp_data_o[63:0]; w7 = e_if.mem_resp_data_o[511:448];
      id = e_if.mem_resp_id_o; last = e_if.mem_resp_last_o; err = e_if.mem_resp_error_o;
      rdy = e_if.mem_req_ready_o;
    end
  endtask

  task automatic set_req(input int inst, input logic vld, input logic [48:0] a, input logic [7:0] l,
                         input logic [3:0] id);
    if (inst == 0) begin
      m_if.mem_req_valid_i = vld; m_if.mem_req_addr_i = a; m_if.mem_req_len_i = l;
      m_if.mem_req_size_i = 3'd6; m_if.mem_req_id_i = id;
    end else begin
      e_if.mem_req_valid_i = vld; e_if.mem_req_addr_i = a; e_if.mem_req_len_i = l;
      e_if.mem_req_size_i = 3'd6; e_if.mem_req_id_i = id;
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting clock edge
  task automatic send_req(input int inst, input logic [48:0] a, input logic [7:0] l, input logic [3:0] id);
    logic v, last, err, rdy; logic [63:0] w0, w7; logic [3:0] rid;
    int k = 0;
    set_req(inst, 1'b1, a, l, id);
    get(inst, v, w0, w7, rid, last, err, rdy);
    while (!rdy && k < 64) begin
      @(negedge clk); k++;
      get(inst, v, w0, w7, rid, last, err, rdy);
    end
    check($sformatf("req_ready_id%0d", id), 64'(rdy), 64'd1);
    @(negedge clk);
    set_req(inst, 1'b0, '0, '0, '0);
  endtask

  // Consumes n beats with ready held high and checks each one against the address model
  task automatic expect_burst(input int inst, input string tag, input logic [48:0] base, input int n,
                              input logic [3:0] id, input logic err_exp, input logic [63:0] seed);
    logic v, last, err, rdy; logic [63:0] w0, w7; logic [3:0] rid;
    logic [48:0] a;
    logic [63:0] e0, e7;
    for (int i = 0; i < n; i++) begin
      int k = 0;
      get(inst, v, w0, w7, rid, last, err, rdy);
      while (!v && k < 64) begin
        @(negedge clk); k++;
        get(inst, v, w0, w7, rid, last, err, rdy);
      end
      a  = base + 49'(64 * i);
      e0 = err_exp ? 64'd0 : ({15'd0, a} ^ seed);
      e7 = err_exp ? 64'd0 : ({15'd0, a + 49'd56} ^ seed);
      check($sformatf("%s_b%0d_valid", tag, i), 64'(v), 64'd1);
      check($sformatf("%s_b%0d_word0", tag, i), w0, e0);
      check($sformatf("%s_b%0d_word7", tag, i), w7, e7);
      check($sformatf("%s_b%0d_last", tag, i), 64'(last), 64'(i == n - 1));
      check($sformatf("%s_b%0d_id", tag, i), 64'(rid), 64'(id));
      check($sformatf("%s_b%0d_error", tag, i), 64'(err), 64'(err_exp));
      @(negedge clk);
    end
    get(inst, v, w0, w7, rid, last, err, rdy);
    check($sformatf("%s_valid_after", tag), 64'(v), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, last, err, rdy; logic [63:0] w0, w7; logic [3:0] rid;
    int k;

    rst = 1'b1;
    rsp_ready = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state on both instances
    for (int inst = 0; inst < 2; inst++) begin
      get(inst, v, w0, w7, rid, last, err, rdy);
      check($sformatf("rst%0d_valid", inst), 64'(v), 64'd0);
      check($sformatf("rst%0d_last", inst), 64'(last), 64'd0);
      check($sformatf("rst%0d_error", inst), 64'(err), 64'd0);
      check($sformatf("rst%0d_data", inst), w0 | w7, 64'd0);
      check($sformatf("rst%0d_id", inst), 64'(rid), 64'd0);
      check($sformatf("rst%0d_ready", inst), 64'(rdy), 64'd1);
    end

    // 1. Single burst with first-beat latency of 1 + LATENCY cycles
    rsp_ready = 1'b1;
    send_req(0, 49'h1000, 8'd3, 4'd5);
    k = 0;
    get(0, v, w0, w7, rid, last, err, rdy);
    while (!v && k < 32) begin
      @(negedge clk); k++;
      get(0, v, w0, w7, rid, last, err, rdy);
    end
    check("t1_latency", 64'(k), 64'd4);
    expect_burst(0, "t1", 49'h1000, 4, 4'd5, 1'b0, 64'd0);

    // 2. Backpressure: ready 1,0,0,1 over a two-beat burst
    rsp_ready = 1'b0;
    send_req(0, 49'h2000, 8'd1, 4'd2);
    k = 0;
    get(0, v, w0, w7, rid, last, err, rdy);
    while (!v && k < 32) begin
      @(negedge clk); k++;
      get(0, v, w0, w7, rid, last, err, rdy);
    end
    check("t2_b0_word0", w0, 64'h2000);
    check("t2_b0_last", 64'(last), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      get(0, v, w0, w7, rid, last, err, rdy);
      check($sformatf("t2_b1_c%0d_valid", c), 64'(v), 64'd1);
      check($sformatf("t2_b1_c%0d_word0", c), w0, 64'h2040);
      check($sformatf("t2_b1_c%0d_id", c), 64'(rid), 64'd2);
      check($sformatf("t2_b1_c%0d_last", c), 64'(last), 64'd1);
      rsp_ready = (c == 2);
      @(negedge clk);
    end
    get(0, v, w0, w7, rid, last, err, rdy);
    check("t2_valid_after", 64'(v), 64'd0);

    // 3. Queue full with responses stalled: req0 moves to the active slot the cycle after its
    //    accept, so the four queue entries fill on the fifth accept
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, 49'(32'h3000 + 32'h100 * i), 8'd0, 4'(i));
      get(0, v, w0, w7, rid, last, err, rdy);
      check($sformatf("t3_ready_before_req%0d", i), 64'(rdy), 64'd1);
      @(negedge clk);
    end
    set_req(0, 1'b0, '0, '0, '0);
    get(0, v, w0, w7, rid, last, err, rdy);
    check("t3_ready_full", 64'(rdy), 64'd0);
    @(negedge clk);
    get(0, v, w0, w7, rid, last, err, rdy);
    check("t3_ready_full_held", 64'(rdy), 64'd0);
    check("t3_stalled_id", 64'(rid), 64'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_burst(0, $sformatf("t3_id%0d", i), 49'(32'h3000 + 32'h100 * i), 1, 4'(i), 1'b0, 64'd0);
    end
    get(0, v, w0, w7, rid, last, err, rdy);
    check("t3_ready_drained", 64'(rdy), 64'd1);

    // 4. Error range, boundary below it, and the data seed
    send_req(1, 49'h8000_0040, 8'd0, 4'd7);
    expect_burst(1, "t4_err", 49'h8000_0040, 1, 4'd7, 1'b1, E_SEED);
    send_req(1, 49'h7FFF_FFFF, 8'd0, 4'd6);
    expect_burst(1, "t4_below", 49'h7FFF_FFC0, 1, 4'd6, 1'b0, E_SEED);
    send_req(1, 49'h40, 8'd0, 4'd1);
    expect_burst(1, "t4_seed", 49'h40, 1, 4'd1, 1'b0, E_SEED);

    // 5. Reset on beat 2 of an 8-beat burst with another request queued
    send_req(0, 49'h5000, 8'd7, 4'd3);
    send_req(0, 49'h6000, 8'd0, 4'd4);
    k = 0;
    get(0, v, w0, w7, rid, last, err, rdy);
    while (!v && k < 32) begin
      @(negedge clk); k++;
      get(0, v, w0, w7, rid, last, err, rdy);
    end
    for (int b = 0; b < 3; b++) begin
      get(0, v, w0, w7, rid, last, err, rdy);
      check($sformatf("t5_b%0d_word0", b), w0, 64'(32'h5000 + 32'h40 * b));
      if (b < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    get(0, v, w0, w7, rid, last, err, rdy);
    check("t5_rst_valid", 64'(v), 64'd0);
    check("t5_rst_ready", 64'(rdy), 64'd1);
    check("t5_rst_last", 64'(last), 64'd0);
    check("t5_rst_data", w0, 64'd0);
    check("t5_rst_id", 64'(rid), 64'd0);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      get(0, v, w0, w7, rid, last, err, rdy);
      if (v) k++;
    end
    check("t5_no_stale_beats", 64'(k), 64'd0);

    // 6. Address wrap at the top of the physical space with a 256-beat burst
    send_req(0, 49'h1_FFFF_FFFF_FFC0, 8'd255, 4'd9);
    expect_burst(0, "t6", 49'h1_FFFF_FFFF_FFC0, 256, 4'd9, 1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
